// File: rtl/inst_fetch_mem.sv
// inst_fetch_mem
//   Byte-addressed instruction memory that sits between the cpu PC/instruction
//   ports and program storage. A fetch takes READ_LATENCY stall cycles, during
//   which BUSYWAIT is raised. The result is presented for one RESP cycle.
//   Misaligned or out-of-range fetches raise ADDR_ERR and return FAULT_WORD.
//   A byte preload port fills the array. STALL_CNT counts stall cycles and
//   saturates at all-ones.
//
// Ports
//   CLK          clock, rising edge
//   RESET        asynchronous reset, active low
//   PC           byte address of the requested instruction
//   READ         level-sensitive fetch request
//   INSTRUCTION  fetched word, little-endian {mem[a+3],..,mem[a]}
//   BUSYWAIT     combinational stall request to the cpu
//   ADDR_ERR     last completed fetch faulted
//   LOAD_EN      preload byte write enable
//   LOAD_ADDR    preload byte address (ignored when >= MEM_BYTES)
//   LOAD_DATA    preload byte
//   STALL_CNT    saturating count of BUSYWAIT-high cycles
//
// state  | meaning
// S_IDLE | waiting for READ; PC is sampled here
// S_WAIT | counting down the remaining latency on the latched address
// S_RESP | INSTRUCTION/ADDR_ERR valid, BUSYWAIT low; always back to S_IDLE

module inst_fetch_mem #(
  parameter int          MEM_BYTES    = 1024,
  parameter int          READ_LATENCY = 2,
  parameter logic [31:0] FAULT_WORD   = 32'h0,
  parameter int          CNT_WIDTH    = 16
) (
  input  logic                 CLK,
  input  logic                 RESET,
  input  logic [31:0]          PC,
  input  logic                 READ,
  output logic [31:0]          INSTRUCTION,
  output logic                 BUSYWAIT,
  output logic                 ADDR_ERR,
  input  logic                 LOAD_EN,
  input  logic [31:0]          LOAD_ADDR,
  input  logic [7:0]           LOAD_DATA,
  output logic [CNT_WIDTH-1:0] STALL_CNT
);

  localparam int          AW        = (MEM_BYTES > 1) ? $clog2(MEM_BYTES) : 1;
  localparam int          LW        = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;
  localparam logic [LW-1:0] CNT_START = LW'(READ_LATENCY - 1);
  localparam logic [31:0] LAST_WORD = 32'(MEM_BYTES - 4);
  localparam logic [31:0] MEM_LIMIT = 32'(MEM_BYTES);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_RESP
  } state_t;

  state_t                 state_q, state_d;
  logic [LW-1:0]          cnt_q, cnt_d;
  logic [31:0]            addr_q, addr_d;
  logic [31:0]            instr_q, instr_d;
  logic                   err_q, err_d;
  logic [CNT_WIDTH-1:0]   stall_q, stall_d;

  // Program storage: not touched by reset so a preloaded image survives it.
  logic [7:0]             mem [MEM_BYTES];

  logic [31:0]            fetch_addr;
  logic [AW-1:0]          fetch_idx;
  logic                   fetch_fault;
  logic [31:0]            fetch_word;
  logic                   load_result;

  assign BUSYWAIT    = RESET & READ & (state_q != S_RESP);
  assign INSTRUCTION = instr_q;
  assign ADDR_ERR    = err_q;
  assign STALL_CNT   = stall_q;

  // With a single-cycle latency the result is loaded straight out of IDLE,
  // so the address comes from PC there and from the latched copy otherwise.
  assign fetch_addr  = (state_q == S_IDLE) ? PC : addr_q;
  assign fetch_idx   = fetch_addr[AW-1:0];
  assign fetch_fault = (fetch_addr[1:0] != 2'b00) || (fetch_addr > LAST_WORD);
  assign fetch_word  = {mem[fetch_idx + AW'(3)], mem[fetch_idx + AW'(2)],
                        mem[fetch_idx + AW'(1)], mem[fetch_idx]};

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    addr_d      = addr_q;
    instr_d     = instr_q;
    err_d       = err_q;
    load_result = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (READ) begin
          addr_d = PC;
          cnt_d  = CNT_START;
          if (CNT_START == '0) begin
            state_d     = S_RESP;
            load_result = 1'b1;
          end else begin
            state_d = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        if (!READ) begin
          // Aborted fetch: previous result stays visible.
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q - 1'b1;
          if (cnt_q == LW'(1)) begin
            state_d     = S_RESP;
            load_result = 1'b1;
          end
        end
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    if (load_result) begin
      err_d   = fetch_fault;
      instr_d = fetch_fault ? FAULT_WORD : fetch_word;
    end

    stall_d = stall_q;
    if (BUSYWAIT && (stall_q != '1)) begin
      stall_d = stall_q + 1'b1;
    end
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      instr_q <= '0;
      err_q   <= 1'b0;
      stall_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      instr_q <= instr_d;
      err_q   <= err_d;
      stall_q <= stall_d;
    end
  end

  // A write on the result-load edge is not seen by that load: the read
  // above samples the array before this non-blocking update lands.
  always_ff @(posedge CLK) begin
    if (LOAD_EN && (LOAD_ADDR < MEM_LIMIT)) begin
      mem[LOAD_ADDR[AW-1:0]] <= LOAD_DATA;
    end
  end

endmodule

// File: tb/tb_inst_fetch_mem.sv
// Bench for inst_fetch_mem: three instances (latency 2 / 4 / 1, the last with
// a 4-bit stall counter) checked against a transaction-level model of the
// byte array, fault rule, stall length and stall count.

module tb_inst_fetch_mem;

  logic        clk;
  logic        rst_n;
  logic [31:0] pc      [3];
  logic        rd      [3];
  logic        ld_en   [3];
  logic [31:0] ld_addr [3];
  logic [7:0]  ld_data [3];

  logic [31:0] instr0, instr1, instr2;
  logic        busy0, busy1, busy2;
  logic        err0, err1, err2;
  logic [15:0] stall0, stall1;
  logic [3:0]  stall2;

  int n_checks = 0;
  int n_errors = 0;
  int cyc      = 0;

  logic [7:0]  mm [3][1024];
  int          es        [3];
  int          last_resp [3];
  bit          chained   [3];
  logic [31:0] last_w    [3];
  logic        last_e    [3];

  inst_fetch_mem #(.MEM_BYTES(1024), .READ_LATENCY(2), .FAULT_WORD(32'h0), .CNT_WIDTH(16)) dut0 (
    .CLK(clk), .RESET(rst_n), .PC(pc[0]), .READ(rd[0]), .INSTRUCTION(instr0),
    .BUSYWAIT(busy0), .ADDR_ERR(err0), .LOAD_EN(ld_en[0]), .LOAD_ADDR(ld_addr[0]),
    .LOAD_DATA(ld_data[0]), .STALL_CNT(stall0));

  inst_fetch_mem #(.MEM_BYTES(1024), .READ_LATENCY(4), .FAULT_WORD(32'hDEADBEEF), .CNT_WIDTH(16)) dut1 (
    .CLK(clk), .RESET(rst_n), .PC(pc[1]), .READ(rd[1]), .INSTRUCTION(instr1),
    .BUSYWAIT(busy1), .ADDR_ERR(err1), .LOAD_EN(ld_en[1]), .LOAD_ADDR(ld_addr[1]),
    .LOAD_DATA(ld_data[1]), .STALL_CNT(stall1));

  inst_fetch_mem #(.MEM_BYTES(1024), .READ_LATENCY(1), .FAULT_WORD(32'h0), .CNT_WIDTH(4)) dut2 (
    .CLK(clk), .RESET(rst_n), .PC(pc[2]), .READ(rd[2]), .INSTRUCTION(instr2),
    .BUSYWAIT(busy2), .ADDR_ERR(err2), .LOAD_EN(ld_en[2]), .LOAD_ADDR(ld_addr[2]),
    .LOAD_DATA(ld_data[2]), .STALL_CNT(stall2));

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1);
  end

  function automatic int rl(input int k);
    return (k == 0) ? 2 : (k == 1) ? 4 : 1;
  endfunction

  function automatic int smax(input int k);
    return (k == 2) ? 15 : 65535;
  endfunction

  function automatic logic [31:0] fw(input int k);
    return (k == 1) ? 32'hDEADBEEF : 32'h0;
  endfunction

  function automatic logic get_busy(input int k);
    case (k)
      0:       return busy0;
      1:       return busy1;
      default: return busy2;
    endcase
  endfunction

  function automatic logic get_err(input int k);
    case (k)
      0:       return err0;
      1:       return err1;
      default: return err2;
    endcase
  endfunction

  function automatic logic [31:0] get_instr(input int k);
    case (k)
      0:       return instr0;
      1:       return instr1;
      default: return instr2;
    endcase
  endfunction

  function automatic logic [31:0] get_stall(input int k);
    case (k)
      0:       return {16'h0, stall0};
      1:       return {16'h0, stall1};
      default: return {28'h0, stall2};
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s act=%h exp=%h t=%0t", tag, act, exp, $time);
    end
  endtask

  // Reference: fault if misaligned or the word would run past the array.
  task automatic model_word(input int k, input logic [31:0] a,
                            output logic [31:0] w, output logic e);
    int ia;
    e = (a[1:0] != 2'b00) || (a > 32'd1020);
    w = fw(k);
    if (!e) begin
      ia = int'(a);
      w  = {mm[k][ia+3], mm[k][ia+2], mm[k][ia+1], mm[k][ia]};
    end
  endtask

  task automatic add_stall(input int k, input int n);
    es[k] = es[k] + n;
    if (es[k] > smax(k)) es[k] = smax(k);
  endtask

  task automatic load(input int k, input logic [31:0] a, input logic [7:0] d);
    ld_en[k] = 1'b1; ld_addr[k] = a; ld_data[k] = d;
    @(negedge clk);
    ld_en[k] = 1'b0;
    if (a < 32'd1024) mm[k][int'(a)] = d;
  endtask

  task automatic load_word(input int k, input logic [31:0] a, input logic [31:0] w);
    for (int b = 0; b < 4; b++) load(k, a + 32'(b), w[8*b +: 8]);
  endtask

  // Called just after a negedge; returns 1ns after the negedge of the RESP cycle.
  task automatic fetch(input int k, input logic [31:0] a, input bit hold);
    logic [31:0] ew;
    logic        ee;
    int          n;
    pc[k] = a; rd[k] = 1'b1;
    #1;
    n = 0;
    while (!get_busy(k) && n < 8) begin @(negedge clk); #1; n++; end
    n = 0;
    while (get_busy(k) && n < 40) begin n++; @(negedge clk); #1; end
    chk($sformatf("stall_cycles k%0d a%h", k, a), 32'(n), 32'(rl(k)));
    model_word(k, a, ew, ee);
    chk($sformatf("instr k%0d a%h", k, a), get_instr(k), ew);
    chk($sformatf("addr_err k%0d a%h", k, a), {31'h0, get_err(k)}, {31'h0, ee});
    add_stall(k, rl(k));
    chk($sformatf("stall_cnt k%0d", k), get_stall(k), 32'(es[k]));
    if (chained[k]) chk($sformatf("throughput k%0d", k), 32'(cyc - last_resp[k]), 32'(rl(k) + 1));
    last_resp[k] = cyc;
    chained[k]   = hold;
    last_w[k]    = ew;
    last_e[k]    = ee;
    if (!hold) rd[k] = 1'b0;
  endtask

  initial begin
    logic [31:0] old_w, a;
    logic        old_e;

    rst_n = 1'b0;
    for (int k = 0; k < 3; k++) begin
      pc[k] = '0; rd[k] = 1'b0; ld_en[k] = 1'b0; ld_addr[k] = '0; ld_data[k] = '0;
      es[k] = 0; last_resp[k] = 0; chained[k] = 1'b0; last_w[k] = '0; last_e[k] = 1'b0;
    end
    rd[0] = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    chk("rst busy forced low", {31'h0, busy0}, 32'h0);
    chk("rst instr", instr0, 32'h0);
    chk("rst addr_err", {31'h0, err0}, 32'h0);
    chk("rst stall", get_stall(0), 32'h0);
    rd[0] = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    // fill every array with random bytes so the model is fully known
    for (int i = 0; i < 1024; i++) begin
      for (int k = 0; k < 3; k++) begin
        ld_en[k] = 1'b1; ld_addr[k] = 32'(i); ld_data[k] = 8'($urandom);
        mm[k][i] = ld_data[k];
      end
      @(negedge clk);
    end
    for (int k = 0; k < 3; k++) ld_en[k] = 1'b0;

    // single fetch, latency 2
    load_word(0, 32'd0, 32'h0500000A);
    fetch(0, 32'd0, 1'b0);
    chk("first fetch stall=2", get_stall(0), 32'd2);

    // back-to-back stream
    load_word(0, 32'd4, 32'h0503001E);
    load_word(0, 32'd8, 32'h05010005);
    fetch(0, 32'd0, 1'b1);
    fetch(0, 32'd4, 1'b1);
    fetch(0, 32'd8, 1'b0);

    // fault boundaries
    fetch(0, 32'd2, 1'b0);
    fetch(0, 32'd1021, 1'b0);
    fetch(0, 32'd1020, 1'b0);
    fetch(0, 32'd1024, 1'b0);
    fetch(0, 32'hFFFF_FFFC, 1'b0);
    fetch(1, 32'd3, 1'b0);

    // out-of-range preload writes must not alias into the array
    load(0, 32'd1024, 8'hEE);
    load(0, 32'h8000_0000, 8'hEE);
    fetch(0, 32'd0, 1'b0);

    // preload landing before the result-load edge is visible
    @(negedge clk);
    pc[0] = 32'd16; rd[0] = 1'b1;
    ld_en[0] = 1'b1; ld_addr[0] = 32'd16; ld_data[0] = 8'hA5;
    mm[0][16] = 8'hA5;
    @(negedge clk);
    ld_en[0] = 1'b0;
    @(negedge clk); #1;
    model_word(0, 32'd16, old_w, old_e);
    chk("preload early visible", instr0, old_w);
    add_stall(0, 2);
    rd[0] = 1'b0;

    // preload on the same edge as the result load returns the old byte
    load(0, 32'd20, 8'h11);
    @(negedge clk);
    pc[0] = 32'd20; rd[0] = 1'b1;
    @(negedge clk);
    ld_en[0] = 1'b1; ld_addr[0] = 32'd20; ld_data[0] = 8'h3C;
    model_word(0, 32'd20, old_w, old_e);
    @(negedge clk);
    ld_en[0] = 1'b0;
    #1;
    chk("preload same edge old", instr0, old_w);
    mm[0][20] = 8'h3C;
    add_stall(0, 2);
    rd[0] = 1'b0;
    fetch(0, 32'd20, 1'b0);

    // abort in the 2nd WAIT cycle (latency 4)
    fetch(1, 32'd4, 1'b0);
    @(negedge clk);
    pc[1] = 32'd6; rd[1] = 1'b1;
    @(negedge clk);
    @(negedge clk);
    #1 rd[1] = 1'b0;
    #1 chk("abort busy drop", {31'h0, busy1}, 32'h0);
    @(negedge clk); #1;
    chk("abort busy idle", {31'h0, busy1}, 32'h0);
    chk("abort instr held", instr1, last_w[1]);
    chk("abort err held", {31'h0, err1}, {31'h0, last_e[1]});
    add_stall(1, 2);
    chk("abort stall", get_stall(1), 32'(es[1]));
    fetch(1, 32'd12, 1'b0);

    // asynchronous reset mid-WAIT
    @(negedge clk);
    pc[0] = 32'd0; rd[0] = 1'b1;
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("async rst instr", instr0, 32'h0);
    chk("async rst busy", {31'h0, busy0}, 32'h0);
    chk("async rst stall", get_stall(0), 32'h0);
    chk("async rst stall k1", get_stall(1), 32'h0);
    for (int k = 0; k < 3; k++) begin es[k] = 0; chained[k] = 1'b0; end
    rd[0] = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    fetch(0, 32'd0, 1'b0);
    chk("mem kept over reset", instr0, 32'h0500000A);

    // saturation of a 4-bit counter, latency 1
    for (int i = 0; i < 20; i++) fetch(2, 32'($urandom_range(0, 255) * 4), (i < 19));
    chk("stall saturated", get_stall(2), 32'd15);
    repeat (3) @(negedge clk);
    #1 chk("stall holds", get_stall(2), 32'd15);

    // randomized mix of preloads and fetches
    for (int it = 0; it < 60; it++) begin
      int k;
      k = int'($urandom_range(0, 1));
      if ($urandom_range(0, 2) == 0) begin
        load(k, 32'($urandom_range(0, 1100)), 8'($urandom));
      end else begin
        case ($urandom_range(0, 3))
          0:       a = 32'($urandom_range(0, 255) * 4);
          1:       a = 32'($urandom_range(0, 1023)) | 32'd1;
          2:       a = 32'($urandom_range(1016, 1023));
          default: a = $urandom;
        endcase
        fetch(k, a, 1'b0);
      end
    end

    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
